instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch front end: the reader side of the 64-word combinational instruction memory. It owns the program counter, drives the memory word address, and captures each returned instruction with its PC into a 2-entry prefetch buffer. It presents instructions to decode over a valid/ready handshake and supports redirect (branch/jump) with flush. Sits between the instruction memory and the decode stage of the 32-bit processor.

## Interface
- ADDR_W, 6, instruction word-address width (64 words)
- DATA_W, 32, instruction width
- NOP_WORD, 32'h0007_8000, value driven on dec_inst when the buffer is empty
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- fetch_en  input  1  1 = fetching allowed; 0 = PC holds and nothing is pushed
- imem_addr  output  ADDR_W  word address to instruction memory
- imem_data  input  DATA_W  instruction word, combinational from imem_addr in the same cycle
- redirect_valid  input  1  single-cycle request to restart fetch at redirect_addr
- redirect_addr  input  ADDR_W  redirect target word address
- dec_valid  output  1  buffer head holds a valid instruction
- dec_ready  input  1  decode accepts the head this cycle
- dec_inst  output  DATA_W  head instruction
- dec_pc  output  ADDR_W  word address of head instruction

## Operation
- State: fetch_pc (ADDR_W), 2-entry FIFO of {pc, inst}, occupancy count (0..2), read/write pointers (1 bit each).
- imem_addr = fetch_pc at all times (register output, no combinational path from inputs).
- pop = dec_valid && dec_ready.
- push = fetch_en && !redirect_valid && (count < 2 || pop). Push writes {fetch_pc, imem_data}, then fetch_pc <= fetch_pc + 1, modulo 2^ADDR_W (63 -> 0, no flag, no stall).
- Simultaneous push and pop: count unchanged, both pointers advance. Full with pop: push allowed (no bubble).
- Redirect: highest priority. On an edge with redirect_valid=1, count <= 0, pointers <= 0, fetch_pc <= redirect_addr. Any concurrent pop still counts as accepted by decode. No push that cycle. Redirect is honoured even when fetch_en=0.
- fetch_en=0: no push, fetch_pc holds. Pops continue draining the buffer.
- Outputs: dec_valid = (count != 0). dec_inst and dec_pc come from the head entry when valid. When empty, dec_inst = NOP_WORD and dec_pc = 0.
- Ordering: instructions leave in fetch order. None is dropped or duplicated, except entries discarded by a redirect.

## Timing
- Reset (async assert, takes effect immediately): fetch_pc=0, count=0, pointers=0. Outputs: imem_addr=0, dec_valid=0, dec_inst=NOP_WORD, dec_pc=0. Deassertion is sampled at the next rising edge.
- Reset mid-operation: all buffered entries are lost and the reset values above apply within the same cycle.
- Fetch latency: instruction at address A is pushed on the edge where fetch_pc=A. dec_valid rises after that edge, so there is 1 cycle from address to availability.
- Redirect latency: redirect at edge N gives dec_valid=0 after N. Target is pushed at edge N+1 and is valid after N+1 (1 bubble cycle).
- Throughput: 1 instruction/cycle sustained with dec_ready=1 and fetch_en=1.
- Backpressure: with dec_ready=0, at most 2 further pushes occur, then fetch_pc holds. imem_addr stays stable while full.
- dec_valid never drops while count != 0 except on redirect or reset. dec_inst and dec_pc are stable while dec_valid && !dec_ready.

## Test plan
- Reset: assert rst mid-cycle -> immediately imem_addr=0, dec_valid=0, dec_inst=32'h0007_8000, dec_pc=0. Release, fetch_en=1, dec_ready=1 -> after edge 1: dec_valid=1, dec_pc=0, dec_inst=32'h0007_8000. After edge 2: dec_pc=1, dec_inst=32'h8008_0001.
- Streaming: dec_ready=1 for 70 cycles -> dec_pc sequence 0,1,...,63,0,1,... with no gaps. The 63->0 wrap is seamless and dec_inst matches the memory word at each pc.
- Backpressure: after reset, dec_ready=0 for 5 cycles -> count saturates at 2, imem_addr holds at 2, and dec_pc=0 is stable. Then dec_ready=1 -> dec_pc sequence 0,1,2,3 on consecutive cycles, with no duplicate and no skip.
- Redirect while full: buffer holds pc 0,1, dec_ready=1, redirect_valid=1, redirect_addr=8 -> next cycle dec_valid=0. Following cycle dec_pc=8, dec_inst=32'h0C03_0A00, then pc 9. pc 1 is never presented.
- fetch_en gating: fetch_en=0 with 2 entries and dec_ready=1 -> 2 pops, then dec_valid=0 and imem_addr unchanged. Set fetch_en=1 -> fetch resumes at the held address.
- Async reset during streaming at pc 20: dec_valid falls without waiting for an edge. After release, fetch restarts at pc 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect request and decode handshake.
// master = fetch unit, slave = the memory/decode environment around it.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_inst;
  logic [ADDR_W-1:0] dec_pc;

  modport master (
    input  fetch_en, imem_data, redirect_valid, redirect_addr, dec_ready,
    output imem_addr, dec_valid, dec_inst, dec_pc
  );

  modport slave (
    output fetch_en, imem_data, redirect_valid, redirect_addr, dec_ready,
    input  imem_addr, dec_valid, dec_inst, dec_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, 2-entry prefetch buffer of {pc, inst},
// valid/ready toward decode, redirect with flush.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 6,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0007_8000
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  entry_t            fifo_q [2];
  logic [1:0]        count;
  logic              rd_ptr, wr_ptr;
  logic              pop, push;

  assign pop  = (count != 2'd0) && bus.dec_ready;
  // A full buffer still accepts a push when the head leaves the same cycle.
  assign push = bus.fetch_en && !bus.redirect_valid && ((count < 2'd2) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= '0;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_addr;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: fetch_pc, inst: bus.imem_data};
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.dec_valid = (count != 2'd0);
  assign bus.dec_inst  = bus.dec_valid ? fifo_q[rd_ptr].inst : NOP_WORD;
  assign bus.dec_pc    = bus.dec_valid ? fifo_q[rd_ptr].pc   : '0;

endmodule
